// File: rtl/ex_stage.sv
// Execute stage: logic/shift/arith/move ALU, HI/LO registers, single-cycle MULTU
// and a 32-step restoring DIVU state machine with upstream stall request.
module ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic              ex_wreg_o,
    output logic [4:0]        ex_wd_o,
    output logic [DATA_W-1:0] ex_wdata_o,
    output logic              wreg_o,
    output logic [4:0]        wd_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stallreq_o
);
    localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2,
                           SEL_ARITH = 3'd3, SEL_MOVE = 3'd4, SEL_MULDIV = 3'd5;
    localparam logic [7:0] OP_OR = 8'h25, OP_AND = 8'h24, OP_XOR = 8'h26,
                           OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT = 8'h2A,
                           OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03,
                           OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12,
                           OP_MTLO = 8'h13, OP_MULTU = 8'h19, OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_hi, r_lo;
    logic [DATA_W-1:0]   r_rem, r_quot, r_dsr;
    logic [4:0]          r_cnt;
    logic [DATA_W-1:0]   w_res;
    logic                w_stall;
    logic                w_div_req;
    logic [DATA_W:0]     w_part, w_sub;
    logic [2*DATA_W-1:0] w_prod;

    assign w_div_req = (alusel_i == SEL_MULDIV) && (aluop_i == OP_DIVU);
    assign w_prod    = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

    // Restoring step: shift next dividend bit into the partial remainder, subtract if no borrow.
    assign w_part = {r_rem, r_quot[DATA_W-1]};
    assign w_sub  = w_part - {1'b0, r_dsr};

    always_comb begin
        w_res = '0;
        case (alusel_i)
            SEL_LOGIC: case (aluop_i)
                OP_OR:   w_res = reg1_i | reg2_i;
                OP_AND:  w_res = reg1_i & reg2_i;
                OP_XOR:  w_res = reg1_i ^ reg2_i;
                default: w_res = '0;
            endcase
            SEL_SHIFT: case (aluop_i)
                OP_SLL:  w_res = reg2_i << reg1_i[4:0];
                OP_SRL:  w_res = reg2_i >> reg1_i[4:0];
                OP_SRA:  w_res = $signed(reg2_i) >>> reg1_i[4:0];
                default: w_res = '0;
            endcase
            SEL_ARITH: case (aluop_i)
                OP_ADDU: w_res = reg1_i + reg2_i;
                OP_SUBU: w_res = reg1_i - reg2_i;
                OP_SLT:  w_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
                default: w_res = '0;
            endcase
            SEL_MOVE: case (aluop_i)
                OP_MFHI: w_res = r_hi;
                OP_MFLO: w_res = r_lo;
                default: w_res = '0;
            endcase
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: if (w_div_req) begin
                w_stall     = 1'b1;
                w_state_nxt = (reg2_i != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                w_stall = 1'b1;
                if (r_cnt == 5'd31) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = S_IDLE;
            w_stall     = 1'b0;
        end
    end

    assign stallreq_o = w_stall;
    assign ex_wreg_o  = wreg_i & ~w_stall & ~flush_i;
    assign ex_wd_o    = wd_i;
    assign ex_wdata_o = w_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreg_o  <= 1'b0;
            wd_o    <= '0;
            wdata_o <= '0;
        end else begin
            wreg_o  <= ex_wreg_o;
            wd_o    <= ex_wd_o;
            wdata_o <= ex_wdata_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_quot  <= '0;
            r_dsr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!flush_i) begin
                if (r_state == S_IDLE && w_div_req) begin
                    if (reg2_i != '0) begin
                        r_quot <= reg1_i;
                        r_rem  <= '0;
                        r_dsr  <= reg2_i;
                        r_cnt  <= '0;
                    end else begin
                        r_quot <= '1;
                        r_rem  <= reg1_i;
                    end
                end else if (r_state == S_RUN) begin
                    r_cnt <= r_cnt + 5'd1;
                    if (!w_sub[DATA_W]) begin
                        r_rem  <= w_sub[DATA_W-1:0];
                        r_quot <= {r_quot[DATA_W-2:0], 1'b1};
                    end else begin
                        r_rem  <= w_part[DATA_W-1:0];
                        r_quot <= {r_quot[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!flush_i) begin
            if (r_state == S_DONE) begin
                r_hi <= r_rem;
                r_lo <= r_quot;
            end else if (alusel_i == SEL_MULDIV && aluop_i == OP_MULTU) begin
                {r_hi, r_lo} <= w_prod;
            end else if (alusel_i == SEL_MOVE && aluop_i == OP_MTHI) begin
                r_hi <= reg1_i;
            end else if (alusel_i == SEL_MOVE && aluop_i == OP_MTLO) begin
                r_lo <= reg1_i;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table plus HI/LO, MULTU and DIVU
// sequences including divide-by-zero, flush and reset aborts.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, flush_i;
    logic        ex_wreg_o, wreg_o, stallreq_o;
    logic [4:0]  ex_wd_o, wd_o;
    logic [31:0] ex_wdata_o, wdata_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o),
        .ex_wdata_o(ex_wdata_o), .wreg_o(wreg_o), .wd_o(wd_o),
        .wdata_o(wdata_o), .stallreq_o(stallreq_o)
    );

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; caller samples combinational outputs afterwards.
    task automatic apply(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wr,
                         input logic fl);
        @(negedge clk);
        aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2;
        wd_i = wd; wreg_i = wr; flush_i = fl;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) begin
            apply(8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
            edge_step();
        end
    endtask

    int stall_cnt;

    initial begin
        vecs[0]  = '{8'h25, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 5'd1,  1'b1, 32'hF0F0_0F0F};
        vecs[1]  = '{8'h24, 3'd1, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd2,  1'b1, 32'h0F00_0F00};
        vecs[2]  = '{8'h26, 3'd1, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd3,  1'b1, 32'hF0F0_0F0F};
        vecs[3]  = '{8'h21, 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5,  1'b1, 32'h0000_0001};
        vecs[4]  = '{8'h23, 3'd3, 32'h0000_0000, 32'h0000_0001, 5'd6,  1'b1, 32'hFFFF_FFFF};
        vecs[5]  = '{8'h2A, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd7,  1'b1, 32'h0000_0001};
        vecs[6]  = '{8'h2A, 3'd3, 32'h0000_0005, 32'hFFFF_FFFF, 5'd8,  1'b1, 32'h0000_0000};
        vecs[7]  = '{8'h7C, 3'd2, 32'h0000_0024, 32'h0000_0001, 5'd9,  1'b1, 32'h0000_0010};
        vecs[8]  = '{8'h02, 3'd2, 32'h0000_0004, 32'h8000_0000, 5'd10, 1'b1, 32'h0800_0000};
        vecs[9]  = '{8'h03, 3'd2, 32'h0000_0004, 32'h8000_0000, 5'd11, 1'b1, 32'hF800_0000};
        vecs[10] = '{8'h03, 3'd2, 32'h0000_001F, 32'h8000_0000, 5'd12, 1'b1, 32'hFFFF_FFFF};
        vecs[11] = '{8'h55, 3'd1, 32'h1234_5678, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'h0000_0000};
        vecs[12] = '{8'h25, 3'd0, 32'h1234_5678, 32'h1111_1111, 5'd14, 1'b1, 32'h0000_0000};
        vecs[13] = '{8'h21, 3'd3, 32'h0000_0003, 32'h0000_0004, 5'd31, 1'b0, 32'h0000_0007};

        rst = 1'b1;
        aluop_i = 8'h0; alusel_i = 3'd0; reg1_i = '0; reg2_i = '0;
        wd_i = '0; wreg_i = 1'b0; flush_i = 1'b0;
        #12;
        chk("rst_wreg_o",   {31'b0, wreg_o},     32'h0);
        chk("rst_wd_o",     {27'b0, wd_o},       32'h0);
        chk("rst_wdata_o",  wdata_o,             32'h0);
        chk("rst_stall",    {31'b0, stallreq_o}, 32'h0);
        rst = 1'b0;

        apply(8'h10, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("rst_hi", ex_wdata_o, 32'h0);
        apply(8'h12, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("rst_lo", ex_wdata_o, 32'h0);

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].wd, vecs[i].wreg, 1'b0);
            chk($sformatf("vec%0d_ex_wdata", i), ex_wdata_o, vecs[i].exp);
            chk($sformatf("vec%0d_ex_wreg", i), {31'b0, ex_wreg_o}, {31'b0, vecs[i].wreg});
            chk($sformatf("vec%0d_ex_wd", i), {27'b0, ex_wd_o}, {27'b0, vecs[i].wd});
            edge_step();
            chk($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].exp);
            chk($sformatf("vec%0d_wreg", i), {31'b0, wreg_o}, {31'b0, vecs[i].wreg});
            chk($sformatf("vec%0d_wd", i), {27'b0, wd_o}, {27'b0, vecs[i].wd});
        end

        // HI/LO moves, and flush suppressing an MTHI
        apply(8'h11, 3'd4, 32'hAAAA_5555, 32'h0, 5'd0, 1'b0, 1'b0); edge_step();
        apply(8'h13, 3'd4, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 1'b0); edge_step();
        apply(8'h10, 3'd4, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
        chk("mthi_mfhi", ex_wdata_o, 32'hAAAA_5555);
        apply(8'h12, 3'd4, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
        chk("mtlo_mflo", ex_wdata_o, 32'h1234_5678);
        apply(8'h11, 3'd4, 32'hDEAD_BEEF, 32'h0, 5'd3, 1'b1, 1'b1);
        chk("flush_ex_wreg", {31'b0, ex_wreg_o}, 32'h0);
        edge_step();
        apply(8'h10, 3'd4, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
        chk("flush_mthi_suppressed", ex_wdata_o, 32'hAAAA_5555);

        // MULTU
        apply(8'h19, 3'd5, 32'hFFFF_FFFF, 32'h2, 5'd0, 1'b0, 1'b0);
        chk("multu_no_stall", {31'b0, stallreq_o}, 32'h0);
        edge_step();
        apply(8'h10, 3'd4, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);
        chk("multu_hi", ex_wdata_o, 32'h0000_0001);
        edge_step();
        chk("mfhi_wdata_o", wdata_o, 32'h0000_0001);
        apply(8'h12, 3'd4, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);
        chk("multu_lo", ex_wdata_o, 32'hFFFF_FFFE);

        // DIVU 100 / 7: 33 stall cycles, bubbles on the registered path
        apply(8'h1B, 3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 1'b0);
        stall_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (!stallreq_o) break;
            stall_cnt++;
            edge_step();
            chk("div_bubble_wreg_o", {31'b0, wreg_o}, 32'h0);
            @(negedge clk);
            #1;
        end
        chk("div_stall_cycles", stall_cnt, 32'd33);
        edge_step();
        apply(8'h10, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("div_hi_rem", ex_wdata_o, 32'd2);
        apply(8'h12, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("div_lo_quot", ex_wdata_o, 32'd14);

        // DIVU by zero: two cycles
        apply(8'h1B, 3'd5, 32'h1234, 32'h0, 5'd9, 1'b1, 1'b0);
        chk("div0_stall_first", {31'b0, stallreq_o}, 32'h1);
        edge_step();
        @(negedge clk);
        #1;
        chk("div0_done_no_stall", {31'b0, stallreq_o}, 32'h0);
        edge_step();
        apply(8'h12, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("div0_lo", ex_wdata_o, 32'hFFFF_FFFF);
        apply(8'h10, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("div0_hi", ex_wdata_o, 32'h0000_1234);

        // Flush at RUN cycle 10 leaves HI/LO untouched
        apply(8'h1B, 3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 1'b0);
        edge_step();
        for (int c = 0; c < 9; c++) edge_step();
        apply(8'h1B, 3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 1'b1);
        chk("flush_run_stall", {31'b0, stallreq_o}, 32'h0);
        edge_step();
        apply(8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        chk("flush_idle_stall", {31'b0, stallreq_o}, 32'h0);
        edge_step();
        nops(40);
        apply(8'h10, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("flush_hi_kept", ex_wdata_o, 32'h0000_1234);
        apply(8'h12, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("flush_lo_kept", ex_wdata_o, 32'hFFFF_FFFF);
        edge_step();

        // Reset mid-RUN aborts divide and clears everything
        apply(8'h1B, 3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 1'b0);
        for (int c = 0; c < 6; c++) edge_step();
        #2;
        rst = 1'b1;
        aluop_i = 8'h0; alusel_i = 3'd0; wreg_i = 1'b0;
        #1;
        chk("rstrun_wreg_o",  {31'b0, wreg_o},     32'h0);
        chk("rstrun_wd_o",    {27'b0, wd_o},       32'h0);
        chk("rstrun_wdata_o", wdata_o,             32'h0);
        chk("rstrun_stall",   {31'b0, stallreq_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nops(40);
        apply(8'h10, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("rstrun_hi", ex_wdata_o, 32'h0);
        chk("rstrun_stall_after", {31'b0, stallreq_o}, 32'h0);
        apply(8'h12, 3'd4, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("rstrun_lo", ex_wdata_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 aluop_i  in  8  ALU operation code from ID.
REQ-005 alusel_i  in  3  operation class: 0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 MOVE, 5 MULDIV.
REQ-006 reg1_i / reg2_i  in  32 each  operands from ID.
REQ-007 wd_i  in  5  destination register address; wreg_i  in  1  write enable.
REQ-008 flush_i  in  1  kills the current instruction and aborts any divide in progress.
REQ-009 ex_wreg_o / ex_wd_o / ex_wdata_o  out  1/5/32  combinational current-cycle result, forwarded to ID's ex_* inputs.
REQ-010 wreg_o / wd_o / wdata_o  out  1/5/32  registered result to MEM.
REQ-011 stallreq_o  out  1  combinational request for upstream to hold its inputs.

Function
REQ-012 Opcodes:
- OR 0x25, AND 0x24, XOR 0x26.
- ADDU 0x21, SUBU 0x23, SLT 0x2A (signed).
- SLL 0x7C, SRL 0x02, SRA 0x03.
- MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
- MULTU 0x19, DIVU 0x1B.
- Any other code gives result 0.
REQ-013 Shifts shall use reg1_i[4:0] as the amount and reg2_i as the value.
REQ-014 ADDU/SUBU shall wrap modulo 2^32; no overflow detection.
REQ-015 SLT shall produce 1 if reg1_i < reg2_i (signed), else 0.
REQ-016 ex_wdata_o shall be selected by alusel_i; ex_wd_o = wd_i.
REQ-017 ex_wreg_o = wreg_i & ~stallreq_o & ~flush_i.
REQ-018 Every rising edge shall register ex_wreg_o/ex_wd_o/ex_wdata_o into wreg_o/wd_o/wdata_o, giving 1-cycle latency.
REQ-019 HI/LO registers (32 bits each):
- MTHI/MTLO write reg1_i at the edge.
- MFHI/MFLO read the registered HI/LO value.
- Forwarding of a same-cycle HI/LO write is not required.
REQ-020 MULTU shall write the unsigned 64-bit product {HI,LO} at the same edge, single cycle, with no stall.
REQ-021 Divide FSM states: IDLE, RUN, DONE.
REQ-022 IDLE -> RUN on DIVU with reg2_i != 0:
- latch dividend and divisor;
- clear the iteration counter to 0.
REQ-023 RUN: one restoring-division step per cycle; counter increments; after the step with counter = 31, go to DONE (32 cycles in RUN).
REQ-024 IDLE -> DONE directly on DIVU with reg2_i == 0; result is quotient 0xFFFFFFFF, remainder = dividend.
REQ-025 DONE -> IDLE unconditionally; HI <= remainder and LO <= quotient at that edge.
REQ-026 stallreq_o shall be 1 while DIVU is presented in IDLE and throughout RUN, and 0 in DONE.
REQ-027 Upstream holds inputs stable while stallreq_o = 1; a divide shall take 34 cycles from first presentation to HI/LO update (2 cycles for divide-by-zero).
REQ-028 flush_i = 1 in any divide state shall return the FSM to IDLE at the next edge without updating HI/LO, and stallreq_o shall be forced to 0.
REQ-029 flush_i in the same cycle as MTHI/MTLO/MULTU shall suppress the HI/LO write.
REQ-030 While stallreq_o = 1, the registered outputs shall capture a bubble (wreg_o = 0).

Reset
REQ-031 rst = 1 shall asynchronously clear the following to 0: wreg_o, wd_o, wdata_o, HI, LO, divider registers, counter; FSM goes to IDLE.
REQ-032 Reset asserted mid-divide shall abort it; no HI/LO update occurs after release.
REQ-033 stallreq_o shall be 0 during reset, provided alusel_i != MULDIV; otherwise it follows REQ-026 from IDLE.

Verification
REQ-034 ADDU 0xFFFFFFFF + 0x00000002, wd 5 -> ex_wdata_o = 0x00000001 same cycle; wdata_o = 1, wd_o = 5, wreg_o = 1 next cycle.
REQ-035 SRA amount 4, value 0x80000000 -> 0xF8000000; SLT with reg1 = 0xFFFFFFFF, reg2 = 1 -> 1.
REQ-036 MULTU 0xFFFFFFFF x 0x2 -> HI = 0x00000001, LO = 0xFFFFFFFE; a following MFHI returns 0x00000001.
REQ-037 DIVU 100 / 7 -> stallreq_o high 33 cycles; then HI = 2, LO = 14; wreg_o = 0 during the stall.
REQ-038 DIVU x / 0 with x = 0x1234 -> after 2 cycles, LO = 0xFFFFFFFF and HI = 0x1234.
REQ-039 DIVU with flush_i asserted at RUN cycle 10 -> IDLE, stallreq_o = 0, HI/LO unchanged; repeat with rst mid-RUN -> all outputs 0.
